hls_deadlock_reporter: RTL and testbench



---
 rtl/hls_deadlock_pkg.sv | 9 +
 rtl/hls_deadlock_prio_enc.sv | 13 +
 rtl/hls_deadlock_reporter.sv | 119 +++++++++++
 tb/tb_hls_deadlock_reporter.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/hls_deadlock_pkg.sv
// hls_deadlock_pkg: shared FSM states, report field positions and event limit
// for the deadlock reporter.
package hls_deadlock_pkg;
    typedef enum logic [2:0] {IDLE, COUNT, REPORT, REPORT_TS, HALT} state_t;
    localparam int RPT_IDX_LSB  = 28;
    localparam int RPT_EVT_LSB  = 16;
    localparam int RPT_SNAP_LSB = 0;
    localparam logic [7:0] EVT_MAX = 8'd255;
endpackage

// File: rtl/hls_deadlock_prio_enc.sv
// hls_deadlock_prio_enc: index of the lowest set bit of req (0 when req is zero).
module hls_deadlock_prio_enc #(
    parameter int NUM_MON = 4
) (
    input  logic [NUM_MON-1:0] req,
    output logic [3:0]         idx
);
    always_comb begin
        idx = '0;
        for (int i = NUM_MON - 1; i >= 0; i--)
            if (req[i]) idx = 4'(i);
    end
endmodule

// File: rtl/hls_deadlock_reporter.sv
// hls_deadlock_reporter: confirms persistent monitor blocking and reports it once.
// Define HLS_DEADLOCK_REPORT_TIMESTAMP_EN to append a cycle-timestamp second beat.
module hls_deadlock_reporter
    import hls_deadlock_pkg::*;
#(
    parameter int NUM_MON = 4,
    parameter int THRESH  = 1024,
    parameter int CNT_W   = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_MON-1:0] mon_block,
    input  logic               clear,
    output logic               deadlock,
    output logic [3:0]         deadlock_idx,
    output logic               rpt_valid,
    input  logic               rpt_ready,
    output logic [31:0]        rpt_data
);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(THRESH - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dl_q, dl_d;
    logic [3:0]       idx_q, idx_d, enc_idx;
    logic [7:0]       evt_q, evt_d;
    logic [31:0]      word_q, word_d;
    logic             any_blk, confirm;

    hls_deadlock_prio_enc #(.NUM_MON(NUM_MON)) u_enc (.req(mon_block), .idx(enc_idx));

    assign any_blk = |mon_block;
    // THRESH==1 confirms straight from IDLE on the first blocked cycle
    assign confirm = any_blk && !clear &&
                     ((state_q == IDLE && THRESH == 1) || (state_q == COUNT && cnt_q == CNT_LAST));

`ifdef HLS_DEADLOCK_REPORT_TIMESTAMP_EN
    logic [31:0] ts_q, ts_d, tsc_q, tsc_d;
    always_comb begin
        ts_d  = ts_q + 32'd1;
        tsc_d = confirm ? ts_q : tsc_q;
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            ts_q  <= '0;
            tsc_q <= '0;
        end else begin
            ts_q  <= ts_d;
            tsc_q <= tsc_d;
        end
    end
    assign rpt_data = (state_q == REPORT_TS) ? tsc_q : word_q;
`else
    assign rpt_data = word_q;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dl_d    = dl_q;
        idx_d   = idx_q;
        evt_d   = evt_q;
        word_d  = word_q;
        case (state_q)
            IDLE, COUNT: begin
                if (clear || !any_blk) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (confirm) begin
                    state_d = REPORT;
                    cnt_d   = '0;
                end else begin
                    state_d = COUNT;
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
`ifdef HLS_DEADLOCK_REPORT_TIMESTAMP_EN
            REPORT:    if (rpt_ready) state_d = REPORT_TS;
`else
            REPORT:    if (rpt_ready) state_d = HALT;
`endif
            REPORT_TS: if (rpt_ready) state_d = HALT;
            HALT: if (clear) begin
                state_d = IDLE;
                dl_d    = 1'b0;
            end
            default: state_d = IDLE;
        endcase
        if (confirm) begin
            dl_d   = 1'b1;
            idx_d  = enc_idx;
            evt_d  = (evt_q == EVT_MAX) ? evt_q : evt_q + 8'd1;
            word_d = (32'(enc_idx) << RPT_IDX_LSB) | (32'(evt_d) << RPT_EVT_LSB) |
                     (32'(mon_block) << RPT_SNAP_LSB);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dl_q    <= 1'b0;
            idx_q   <= '0;
            evt_q   <= '0;
            word_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dl_q    <= dl_d;
            idx_q   <= idx_d;
            evt_q   <= evt_d;
            word_q  <= word_d;
        end
    end

    assign deadlock     = dl_q;
    assign deadlock_idx = idx_q;
    assign rpt_valid    = (state_q == REPORT) || (state_q == REPORT_TS);
endmodule

// File: tb/tb_hls_deadlock_reporter.sv
// tb_hls_deadlock_reporter: directed stimulus, run-length reference model checked
// every cycle, plus literal expectations for the key scenarios.
module tb_hls_deadlock_reporter;
    localparam int THRESH = 8;

    logic        clock = 1'b0, reset = 1'b1, clear = 1'b0, rpt_ready = 1'b0;
    logic [3:0]  mon_block = '0;
    logic        deadlock, rpt_valid;
    logic [3:0]  deadlock_idx;
    logic [31:0] rpt_data;
    int          n_pass = 0, n_total = 0;

    hls_deadlock_reporter #(.NUM_MON(4), .THRESH(THRESH), .CNT_W(16)) dut (
        .clock(clock), .reset(reset), .mon_block(mon_block), .clear(clear),
        .deadlock(deadlock), .deadlock_idx(deadlock_idx), .rpt_valid(rpt_valid),
        .rpt_ready(rpt_ready), .rpt_data(rpt_data)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Reference model: count consecutive blocked cycles while armed; reaching
    // THRESH produces a report that lasts until accepted, then waits for clear.
    bit          started = 0, m_dl = 0, m_valid = 0, m_halt = 0;
    int          m_run = 0, m_evt = 0;
    logic [3:0]  m_idx = '0;
    logic [31:0] m_data = '0;

    always @(posedge clock) begin
        logic r, c, rdy;
        logic [3:0] b;
        r = reset; c = clear; rdy = rpt_ready; b = mon_block;
        if (r) begin
            started = 1; m_dl = 0; m_valid = 0; m_halt = 0;
            m_run = 0; m_evt = 0; m_idx = '0; m_data = '0;
        end else if (m_valid) begin
            if (rdy) begin m_valid = 0; m_halt = 1; end
        end else if (m_halt) begin
            if (c) begin m_halt = 0; m_dl = 0; m_run = 0; end
        end else if (c || b == 4'd0) begin
            m_run = 0;
        end else begin
            m_run++;
            if (m_run == THRESH) begin
                m_run = 0; m_valid = 1; m_dl = 1;
                for (int i = 3; i >= 0; i--) if (b[i]) m_idx = 4'(i);
                m_evt = (m_evt >= 255) ? 255 : m_evt + 1;
                m_data = {m_idx, 4'h0, 8'(m_evt), 12'h0, b};
            end
        end
        #1;
        if (started) begin
            chk("model_deadlock", 32'(deadlock), 32'(m_dl));
            chk("model_valid", 32'(rpt_valid), 32'(m_valid));
            chk("model_idx", 32'(deadlock_idx), 32'(m_idx));
            if (m_valid) chk("model_data", rpt_data, m_data);
        end
    end

    initial begin
        step(2);
        reset = 1'b0;
        chk("rst_deadlock", 32'(deadlock), 32'd0);
        chk("rst_valid", 32'(rpt_valid), 32'd0);
        chk("rst_data", rpt_data, 32'd0);
        chk("rst_idx", 32'(deadlock_idx), 32'd0);

        // persistent block, ready high
        mon_block = 4'b0110; rpt_ready = 1'b1;
        step(7);
        chk("persist_early", 32'(deadlock), 32'd0);
        step(1);
        chk("persist_dl", 32'(deadlock), 32'd1);
        chk("persist_valid", 32'(rpt_valid), 32'd1);
        chk("persist_data", rpt_data, 32'h1001_0006);
        mon_block = '0;
        step(1);
        chk("persist_hs_valid", 32'(rpt_valid), 32'd0);
        step(3);
        chk("halt_sticky", 32'(deadlock), 32'd1);
        clear = 1'b1; step(1); clear = 1'b0;
        chk("clear_dl", 32'(deadlock), 32'd0);
        chk("clear_idx_kept", 32'(deadlock_idx), 32'd1);

        // glitch restarts the count
        mon_block = 4'b1111; step(7);
        mon_block = 4'b0000; step(1);
        mon_block = 4'b1111; step(7);
        mon_block = 4'b0000; step(2);
        chk("glitch_dl", 32'(deadlock), 32'd0);

        // backpressure with ignored clear
        rpt_ready = 1'b0; mon_block = 4'b1000;
        step(8);
        chk("bp_valid", 32'(rpt_valid), 32'd1);
        chk("bp_data", rpt_data, 32'h3002_0008);
        mon_block = '0;
        step(5);
        clear = 1'b1; step(1); clear = 1'b0;
        step(14);
        chk("bp_valid_held", 32'(rpt_valid), 32'd1);
        chk("bp_data_held", rpt_data, 32'h3002_0008);
        chk("bp_dl_held", 32'(deadlock), 32'd1);
        rpt_ready = 1'b1; step(1);
        chk("bp_hs", 32'(rpt_valid), 32'd0);
        clear = 1'b1; step(1); clear = 1'b0;

        // reset in COUNT, then in REPORT
        mon_block = 4'b0001; step(5);
        reset = 1'b1; step(1); reset = 1'b0;
        chk("rstcnt_dl", 32'(deadlock), 32'd0);
        chk("rstcnt_idx", 32'(deadlock_idx), 32'd0);
        rpt_ready = 1'b0;
        step(7);
        chk("rstcnt_recount", 32'(deadlock), 32'd0);
        step(1);
        chk("rstcnt_confirm", 32'(rpt_valid), 32'd1);
        chk("rstcnt_data", rpt_data, 32'h0001_0001);
        mon_block = '0;
        reset = 1'b1; step(1); reset = 1'b0;
        chk("rstrpt_valid", 32'(rpt_valid), 32'd0);
        chk("rstrpt_dl", 32'(deadlock), 32'd0);
        chk("rstrpt_data", rpt_data, 32'd0);

        // repeated confirmations saturate the event count
        rpt_ready = 1'b1;
        for (int i = 0; i < 260; i++) begin
            mon_block = 4'b0100; step(8);
            chk("sat_evt", 32'(rpt_data[23:16]), (i + 1 > 255) ? 32'd255 : 32'(i + 1));
            chk("sat_idx", 32'(rpt_data[31:28]), 32'd2);
            mon_block = '0; step(1);
            clear = 1'b1; step(1); clear = 1'b0;
        end
        chk("sat_final", 32'(rpt_data), 32'h20FF_0004);

        step(2);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
